// File: rtl/gbt_rx_pattern_checker.sv
// gbt_rx_pattern_checker: checks the {cnt,cnt} GBT link test pattern in the rx frame-clock domain.
// Defining GBT_PATTERN_CHECKER_CAPTURE_EN adds first-mismatch capture outputs (cap_*).
module gbt_rx_pattern_checker #(
   parameter int unsigned HALF_W      = 32,
   parameter int unsigned LOCK_FRAMES = 16,
   parameter int unsigned UNLOCK_ERRS = 4,
   parameter int unsigned ERR_CNT_W   = 16
) (
   input  logic                  clk_ik,
   input  logic                  rst_ir,
   input  logic                  link_ready_i,
   input  logic                  valid_i,
   input  logic [2*HALF_W-1:0]   data_i,
   input  logic                  clear_i,
   output logic                  locked_o,
   output logic                  error_o,
   output logic [ERR_CNT_W-1:0]  err_cnt_o,
   output logic [31:0]           frame_cnt_o,
   output logic [1:0]            state_o
`ifdef GBT_PATTERN_CHECKER_CAPTURE_EN
   ,
   output logic                  cap_valid_o,
   output logic [HALF_W-1:0]     cap_exp_o,
   output logic [2*HALF_W-1:0]   cap_data_o
`endif
);

   // Run counters only ever hold up to threshold-1; the threshold itself triggers the transition.
   localparam int unsigned GOOD_W = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
   localparam int unsigned BAD_W  = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;

   localparam logic [HALF_W-1:0]    EXP_ONE     = HALF_W'(1);
   localparam logic [GOOD_W-1:0]    GOOD_ONE    = GOOD_W'(1);
   localparam logic [BAD_W-1:0]     BAD_ONE     = BAD_W'(1);
   localparam logic [ERR_CNT_W-1:0] ERR_ONE     = ERR_CNT_W'(1);
   localparam logic [GOOD_W-1:0]    LOCK_LAST   = GOOD_W'(LOCK_FRAMES - 1);
   localparam logic [BAD_W-1:0]     UNLOCK_LAST = BAD_W'(UNLOCK_ERRS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEEK    = 2'd1,
      ACQUIRE = 2'd2,
      LOCKED  = 2'd3
   } state_t;

   state_t              state_q;
   logic [HALF_W-1:0]   expected_q;
   logic [GOOD_W-1:0]   good_run_q;
   logic [BAD_W-1:0]    bad_run_q;

   logic [HALF_W-1:0]   half_hi;
   logic [HALF_W-1:0]   half_lo;
   logic                coherent;
   logic                frame_good;
   logic                locked_frame;
   logic                locked_bad;

   always_comb begin
      half_hi      = data_i[2*HALF_W-1:HALF_W];
      half_lo      = data_i[HALF_W-1:0];
      coherent     = (half_hi == half_lo);
      frame_good   = coherent && (half_lo == expected_q);
      locked_frame = link_ready_i && valid_i && (state_q == LOCKED);
      locked_bad   = locked_frame && !frame_good;
   end

   always_comb state_o = state_q;

   // Expected value tracks the sender on every strobe, resyncing to the low half when coherent.
   always_ff @(posedge clk_ik or posedge rst_ir) begin
      if (rst_ir)
         expected_q <= '0;
      else if (valid_i)
         expected_q <= (coherent ? half_lo : expected_q) + EXP_ONE;
   end

   always_ff @(posedge clk_ik or posedge rst_ir) begin
      if (rst_ir) begin
         state_q    <= IDLE;
         locked_o   <= 1'b0;
         error_o    <= 1'b0;
         good_run_q <= '0;
         bad_run_q  <= '0;
      end else begin
         error_o <= 1'b0;
         if (!link_ready_i) begin
            state_q    <= IDLE;
            locked_o   <= 1'b0;
            good_run_q <= '0;
            bad_run_q  <= '0;
         end else begin
            unique case (state_q)
               IDLE: state_q <= SEEK;
               SEEK: begin
                  if (valid_i && coherent) begin
                     if (LOCK_FRAMES == 1) begin
                        state_q    <= LOCKED;
                        locked_o   <= 1'b1;
                        bad_run_q  <= '0;
                        good_run_q <= '0;
                     end else begin
                        state_q    <= ACQUIRE;
                        good_run_q <= GOOD_ONE;
                     end
                  end
               end
               ACQUIRE: begin
                  if (valid_i) begin
                     if (!frame_good) begin
                        state_q    <= SEEK;
                        good_run_q <= '0;
                     end else if (good_run_q >= LOCK_LAST) begin
                        state_q    <= LOCKED;
                        locked_o   <= 1'b1;
                        bad_run_q  <= '0;
                        good_run_q <= '0;
                     end else begin
                        good_run_q <= good_run_q + GOOD_ONE;
                     end
                  end
               end
               LOCKED: begin
                  if (valid_i) begin
                     if (frame_good) begin
                        bad_run_q <= '0;
                     end else begin
                        error_o <= 1'b1;
                        if (bad_run_q >= UNLOCK_LAST) begin
                           state_q   <= SEEK;
                           locked_o  <= 1'b0;
                           bad_run_q <= '0;
                        end else begin
                           bad_run_q <= bad_run_q + BAD_ONE;
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_ik or posedge rst_ir) begin
      if (rst_ir) begin
         err_cnt_o   <= '0;
         frame_cnt_o <= '0;
      end else if (clear_i) begin
         err_cnt_o   <= '0;
         frame_cnt_o <= '0;
      end else begin
         if (locked_frame && !(&frame_cnt_o))
            frame_cnt_o <= frame_cnt_o + 32'd1;
         if (locked_bad && !(&err_cnt_o))
            err_cnt_o <= err_cnt_o + ERR_ONE;
      end
   end

`ifdef GBT_PATTERN_CHECKER_CAPTURE_EN
   // Only the first mismatch since the last clear is kept for diagnosis.
   always_ff @(posedge clk_ik or posedge rst_ir) begin
      if (rst_ir) begin
         cap_valid_o <= 1'b0;
         cap_exp_o   <= '0;
         cap_data_o  <= '0;
      end else if (clear_i) begin
         cap_valid_o <= 1'b0;
         cap_exp_o   <= '0;
         cap_data_o  <= '0;
      end else if (locked_bad && !cap_valid_o) begin
         cap_valid_o <= 1'b1;
         cap_exp_o   <= expected_q;
         cap_data_o  <= data_i;
      end
   end
`endif

endmodule

// File: tb/tb_gbt_rx_pattern_checker.sv
// Bench for gbt_rx_pattern_checker: vector table, directed corner sequences and random traffic vs a frame-level model.
module tb_gbt_rx_pattern_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        lr, v, clr;
   logic [63:0] d;

   logic        lk0, er0, lk1, er1;
   logic [15:0] ec0;
   logic [1:0]  ec1;
   logic [31:0] fc0, fc1;
   logic [1:0]  st0, st1;
`ifdef GBT_PATTERN_CHECKER_CAPTURE_EN
   logic        cv0, cv1;
   logic [31:0] ce0, ce1;
   logic [63:0] cd0, cd1;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   gbt_rx_pattern_checker dut0 (
      .clk_ik(clk), .rst_ir(rst), .link_ready_i(lr), .valid_i(v), .data_i(d), .clear_i(clr),
      .locked_o(lk0), .error_o(er0), .err_cnt_o(ec0), .frame_cnt_o(fc0), .state_o(st0)
`ifdef GBT_PATTERN_CHECKER_CAPTURE_EN
      , .cap_valid_o(cv0), .cap_exp_o(ce0), .cap_data_o(cd0)
`endif
   );

   gbt_rx_pattern_checker #(.HALF_W(32), .LOCK_FRAMES(1), .UNLOCK_ERRS(8), .ERR_CNT_W(2)) dut1 (
      .clk_ik(clk), .rst_ir(rst), .link_ready_i(lr), .valid_i(v), .data_i(d), .clear_i(clr),
      .locked_o(lk1), .error_o(er1), .err_cnt_o(ec1), .frame_cnt_o(fc1), .state_o(st1)
`ifdef GBT_PATTERN_CHECKER_CAPTURE_EN
      , .cap_valid_o(cv1), .cap_exp_o(ce1), .cap_data_o(cd1)
`endif
   );

   // Frame-level reference: state as an integer 0..3, counts as plain integers.
   typedef struct {
      int          st;
      logic [31:0] exp;
      int          good;
      int          bad;
      longint      ec;
      longint      fc;
      bit          err;
      bit          capv;
      logic [31:0] cexp;
      logic [63:0] cdat;
      int          lockf;
      int          unl;
      longint      ecmax;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t mreset(input int lockf, input int unl, input int ecw);
      mdl_t m;
      m.st = 0; m.exp = '0; m.good = 0; m.bad = 0; m.ec = 0; m.fc = 0; m.err = 0;
      m.capv = 0; m.cexp = '0; m.cdat = '0;
      m.lockf = lockf; m.unl = unl; m.ecmax = (64'd1 << ecw) - 1;
      return m;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input bit lr_s, input bit v_s, input bit clr_s,
                                  input logic [63:0] dd);
      mdl_t n;
      bit   coh, fgood;
      n     = m;
      n.err = 0;
      coh   = (dd[63:32] == dd[31:0]);
      fgood = coh && (dd[31:0] == m.exp);
      if (v_s) n.exp = coh ? dd[31:0] + 32'd1 : m.exp + 32'd1;
      if (!lr_s) n.st = 0;
      else if (m.st == 0) n.st = 1;
      else if (v_s && m.st == 1) begin
         if (coh) begin
            n.good = 1;
            n.st   = (n.good >= m.lockf) ? 3 : 2;
         end
      end else if (v_s && m.st == 2) begin
         if (fgood) begin
            n.good = m.good + 1;
            if (n.good >= m.lockf) n.st = 3;
         end else begin
            n.st = 1; n.good = 0;
         end
      end else if (v_s && m.st == 3) begin
         if (n.fc < 64'hFFFF_FFFF) n.fc = n.fc + 1;
         if (fgood) n.bad = 0;
         else begin
            n.err = 1;
            if (n.ec < m.ecmax) n.ec = n.ec + 1;
            if (!m.capv) begin n.capv = 1; n.cexp = m.exp; n.cdat = dd; end
            n.bad = m.bad + 1;
            if (n.bad >= m.unl) n.st = 1;
         end
      end
      if (n.st == 3 && m.st != 3) n.bad = 0;
      if (clr_s) begin n.ec = 0; n.fc = 0; n.capv = 0; n.cexp = '0; n.cdat = '0; end
      return n;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic cmp_all();
      chk("d0.state", st0, m0.st);     chk("d0.locked", lk0, m0.st == 3);
      chk("d0.error", er0, m0.err);    chk("d0.err_cnt", ec0, m0.ec);
      chk("d0.frame_cnt", fc0, m0.fc);
      chk("d1.state", st1, m1.st);     chk("d1.locked", lk1, m1.st == 3);
      chk("d1.error", er1, m1.err);    chk("d1.err_cnt", ec1, m1.ec);
      chk("d1.frame_cnt", fc1, m1.fc);
`ifdef GBT_PATTERN_CHECKER_CAPTURE_EN
      chk("d0.cap_valid", cv0, m0.capv); chk("d0.cap_exp", ce0, m0.cexp); chk("d0.cap_data", cd0, m0.cdat);
      chk("d1.cap_valid", cv1, m1.capv); chk("d1.cap_exp", ce1, m1.cexp); chk("d1.cap_data", cd1, m1.cdat);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      m0 = mstep(m0, lr, v, clr, d);
      m1 = mstep(m1, lr, v, clr, d);
      #1;
      cmp_all();
   endtask

   task automatic drive(input bit l, input bit vv, input bit c, input logic [63:0] dd);
      lr = l; v = vv; clr = c; d = dd;
      tick();
   endtask

   typedef struct {
      bit          lr, v, clr;
      logic [63:0] d;
      int          st;
      bit          lk, er;
      int          ec, fc;
   } vec_t;

   function automatic vec_t mkv(input bit l, input bit vv, input bit c, input logic [63:0] dd,
                                input int st, input bit lk, input bit er, input int ec, input int fc);
      vec_t t;
      t.lr = l; t.v = vv; t.clr = c; t.d = dd; t.st = st; t.lk = lk; t.er = er; t.ec = ec; t.fc = fc;
      return t;
   endfunction

   vec_t tbl[24];

   initial begin
      logic [31:0] pc;
      logic [31:0] base;
      int          r;

      tbl[0] = mkv(1, 0, 0, 64'd0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         tbl[i+1] = mkv(1, 1, 0, {32'(i), 32'(i)}, (i >= 15) ? 3 : 2, i >= 15, 0, 0, (i >= 16) ? i - 15 : 0);
      tbl[21] = mkv(1, 1, 0, 64'h00000005_00000006, 3, 1, 1, 1, 5);
      tbl[22] = mkv(1, 1, 0, {32'd21, 32'd21}, 3, 1, 0, 1, 6);
      tbl[23] = mkv(1, 0, 0, 64'd0, 3, 1, 0, 1, 6);

      rst = 1'b1; lr = 1'b0; v = 1'b0; clr = 1'b0; d = '0;
      m0 = mreset(16, 4, 16);
      m1 = mreset(1, 8, 2);
      repeat (2) @(posedge clk);
      #1;
      cmp_all();
      rst = 1'b0;

      // lock-up on {k,k}, single injected mismatch, resume
      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].lr, tbl[i].v, tbl[i].clr, tbl[i].d);
         chk($sformatf("tbl%0d.state", i), st0, tbl[i].st);
         chk($sformatf("tbl%0d.locked", i), lk0, tbl[i].lk);
         chk($sformatf("tbl%0d.error", i), er0, tbl[i].er);
         chk($sformatf("tbl%0d.err_cnt", i), ec0, tbl[i].ec);
         chk($sformatf("tbl%0d.frame_cnt", i), fc0, tbl[i].fc);
      end

      // four consecutive incoherent frames unlock
      drive(1, 0, 1, 64'd0);
      chk("clr.err_cnt", ec0, 0); chk("clr.frame_cnt", fc0, 0); chk("clr.locked", lk0, 1);
      for (int i = 0; i < 4; i++)
         drive(1, 1, 0, 64'h12345678_9ABCDEF0 ^ 64'(i));
      chk("unlock.err_cnt", ec0, 4); chk("unlock.state", st0, 1); chk("unlock.locked", lk0, 0);
      chk("unlock.frame_cnt", fc0, 4);

      // relock just below the wrap point, then cross it while locked
      base = 32'hFFFF_FFEE;
      for (int i = 0; i < 16; i++) begin
         pc = base + 32'(i);
         drive(1, 1, 0, {pc, pc});
      end
      chk("relock.locked", lk0, 1); chk("relock.frame_cnt", fc0, 4);
      for (int i = 0; i < 4; i++) begin
         pc = 32'hFFFF_FFFE + 32'(i);
         drive(1, 1, 0, {pc, pc});
         chk("wrap.error", er0, 0);
      end
      chk("wrap.frame_cnt", fc0, 8); chk("wrap.err_cnt", ec0, 4); chk("wrap.locked", lk0, 1);

      // clear coincident with a bad frame, then error-counter saturation on the 2-bit instance
      drive(1, 1, 1, 64'h00000005_00000006);
      chk("clrbad.error", er0, 1); chk("clrbad.err_cnt", ec0, 0); chk("clrbad.frame_cnt", fc0, 0);
      for (int i = 0; i < 5; i++)
         drive(1, 1, 0, 64'hDEAD0000_BEEF0000 + 64'(i));
      chk("sat.d1.err_cnt", ec1, 3); chk("sat.d1.locked", lk1, 1);

      // link drop mid-acquire
      for (int i = 0; i < 3; i++)
         drive(1, 1, 0, {32'h100 + 32'(i), 32'h100 + 32'(i)});
      chk("acq.state", st0, 2);
      drive(0, 0, 0, 64'd0);
      chk("drop.state", st0, 0); chk("drop.locked", lk0, 0); chk("drop.d1.locked", lk1, 0);
      drive(1, 0, 0, 64'd0);
      chk("rise.state", st0, 1);

      // randomized traffic: mostly the running pattern with occasional jumps, corruption, clears, link drops
      pc = 32'hFFFF_FF80;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            #2 rst = 1'b1;
            #1;
            m0 = mreset(16, 4, 16);
            m1 = mreset(1, 8, 2);
            cmp_all();
            rst = 1'b0;
         end
         lr  = ($urandom_range(0, 199) != 0);
         v   = ($urandom_range(0, 9) < 7);
         clr = ($urandom_range(0, 49) == 0);
         if (!v) d = {$urandom, $urandom};
         else begin
            r = $urandom_range(0, 99);
            if (r < 3) d = {pc ^ 32'(1 << $urandom_range(0, 31)), pc};
            else if (r < 5) begin
               pc = $urandom;
               d  = {pc, pc};
            end else d = {pc, pc};
            pc = pc + 32'd1;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
